biriscv_icache_resp: RTL

//  Responder for the frontend's instruction-fetch request interface (rd/accept/valid/inst, 64-bit fetch).

---
 rtl/biriscv_icache_resp_if.sv | 45 ++++
 rtl/biriscv_icache_resp.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/biriscv_icache_resp_if.sv
`default_nettype none
// ============================================================================
//  Module   : biriscv_icache_resp_if
//  Brief    : Fetch-request and instruction-memory signal bundle for the
//             biriscv_icache_resp fetch responder.
//  Revision : 1.0  initial release
// ============================================================================
interface biriscv_icache_resp_if;
    // Fetch request side
    logic        req_rd_i;
    logic        req_flush_i;
    logic        req_invalidate_i;
    logic [31:0] req_pc_i;
    logic [1:0]  req_priv_i;
    logic        req_accept_o;
    logic        req_valid_o;
    logic        req_error_o;
    logic        req_page_fault_o;
    logic [63:0] req_inst_o;

    // 32-bit instruction memory side
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_accept_i;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic        mem_error_i;

    // Environment view: fetch unit plus memory
    modport master (
        output req_rd_i, req_flush_i, req_invalidate_i, req_pc_i, req_priv_i,
        input  req_accept_o, req_valid_o, req_error_o, req_page_fault_o, req_inst_o,
        input  mem_rd_o, mem_addr_o,
        output mem_accept_i, mem_valid_i, mem_data_i, mem_error_i
    );

    // Responder view
    modport slave (
        input  req_rd_i, req_flush_i, req_invalidate_i, req_pc_i, req_priv_i,
        output req_accept_o, req_valid_o, req_error_o, req_page_fault_o, req_inst_o,
        output mem_rd_o, mem_addr_o,
        input  mem_accept_i, mem_valid_i, mem_data_i, mem_error_i
    );
endinterface
`default_nettype wire

// File: rtl/biriscv_icache_resp.sv
`default_nettype none
// ============================================================================
//  Module   : biriscv_icache_resp
//  Brief    : Blocking 64-bit fetch responder with a one-line fetch buffer,
//             served by two reads on a 32-bit single-outstanding memory port.
//  Revision : 1.0  initial release
// ============================================================================
module biriscv_icache_resp #(
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter int          MEM_SIZE_W = 16
) (
    input wire                   clk_i,
    input wire                   rst_n,
    biriscv_icache_resp_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LO_ADDR = 3'd1,
        ST_LO_DATA = 3'd2,
        ST_HI_ADDR = 3'd3,
        ST_HI_DATA = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [28:0] r_line;
    logic [31:0] r_lo_word;
    logic        r_no_fill;

    logic        r_buf_valid;
    logic [28:0] r_buf_tag;
    logic [63:0] r_buf_data;

    logic        r_resp_valid;
    logic        r_resp_error;
    logic [63:0] r_resp_inst;

    logic        w_resp_valid;
    logic        w_resp_error;
    logic [63:0] w_resp_inst;
    logic        w_mem_rd;
    logic [31:0] w_mem_addr;

    logic        w_clear;
    logic [32:0] w_pc_offset;
    logic        w_in_range;
    logic        w_take;
    logic        w_hit;
    logic        w_fill;
    logic        w_unused_bits;

    assign w_clear     = bus.req_flush_i | bus.req_invalidate_i;
    // Offset is computed one bit wider so a pc below MEM_BASE wraps into bit 32
    assign w_pc_offset = {1'b0, bus.req_pc_i} - {1'b0, MEM_BASE};
    assign w_in_range  = ((w_pc_offset >> MEM_SIZE_W) == 33'd0);
    assign w_take      = bus.req_rd_i && (r_state == ST_IDLE);
    assign w_hit       = r_buf_valid && (r_buf_tag == bus.req_pc_i[31:3]) && !w_clear;
    assign w_fill      = (r_state == ST_HI_DATA) && bus.mem_valid_i && !bus.mem_error_i
                         && !r_no_fill && !w_clear;

    // Privilege and the sub-line pc bits have no effect on a fetch
    assign w_unused_bits = ^{bus.req_priv_i, bus.req_pc_i[2:0]};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_rd     = 1'b0;
        w_mem_addr   = 32'h0000_0000;
        w_resp_valid = 1'b0;
        w_resp_error = 1'b0;
        w_resp_inst  = r_resp_inst;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.req_rd_i) begin
                    if (!w_in_range) begin
                        w_resp_valid = 1'b1;
                        w_resp_error = 1'b1;
                        w_resp_inst  = 64'd0;
                    end else if (w_hit) begin
                        w_resp_valid = 1'b1;
                        w_resp_inst  = r_buf_data;
                    end else begin
                        w_state_next = ST_LO_ADDR;
                    end
                end
            end
            ST_LO_ADDR: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = {r_line, 3'b000};
                if (bus.mem_accept_i) begin
                    w_state_next = ST_LO_DATA;
                end
            end
            ST_LO_DATA: begin
                if (bus.mem_valid_i) begin
                    if (bus.mem_error_i) begin
                        w_resp_valid = 1'b1;
                        w_resp_error = 1'b1;
                        w_resp_inst  = 64'd0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_HI_ADDR;
                    end
                end
            end
            ST_HI_ADDR: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = {r_line, 3'b100};
                if (bus.mem_accept_i) begin
                    w_state_next = ST_HI_DATA;
                end
            end
            ST_HI_DATA: begin
                if (bus.mem_valid_i) begin
                    w_resp_valid = 1'b1;
                    w_resp_error = bus.mem_error_i;
                    w_resp_inst  = {bus.mem_data_i, r_lo_word};
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_inst  <= 64'd0;
            r_line       <= 29'd0;
            r_lo_word    <= 32'd0;
            r_no_fill    <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_buf_tag    <= 29'd0;
            r_buf_data   <= 64'd0;
        end else begin
            r_resp_valid <= w_resp_valid;
            r_resp_error <= w_resp_error;
            r_resp_inst  <= w_resp_inst;

            if (w_take) begin
                r_line <= bus.req_pc_i[31:3];
            end
            if ((r_state == ST_LO_DATA) && bus.mem_valid_i) begin
                r_lo_word <= bus.mem_data_i;
            end

            // A flush seen while a miss is in flight makes its data stale for the buffer
            if (w_take) begin
                r_no_fill <= 1'b0;
            end else if (w_clear && (r_state != ST_IDLE)) begin
                r_no_fill <= 1'b1;
            end

            if (w_clear) begin
                r_buf_valid <= 1'b0;
            end else if (w_fill) begin
                r_buf_valid <= 1'b1;
            end
            if (w_fill) begin
                r_buf_tag  <= r_line;
                r_buf_data <= {bus.mem_data_i, r_lo_word};
            end
        end
    end

    assign bus.req_accept_o     = (r_state == ST_IDLE);
    assign bus.req_valid_o      = r_resp_valid;
    assign bus.req_error_o      = r_resp_error;
    assign bus.req_page_fault_o = 1'b0;
    assign bus.req_inst_o       = r_resp_inst;
    assign bus.mem_rd_o         = w_mem_rd;
    assign bus.mem_addr_o       = w_mem_addr;

endmodule
`default_nettype wire
